// File: rtl/seg_scan_driver.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Latches a hex value and dp mask, then time-multiplexes digits with anti-ghost guard.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    blank
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [VAL_W-1:0]      sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  dp_n_q, dp_n_d;
    logic                  blank_q, blank_d;

    logic [3:0]            digit_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] lead_zero;

    // Shadow registers: the only source of displayed data.
    always_comb begin
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        if (load) begin
            sh_val_d = value_in;
            sh_dp_d  = dp_in;
        end
    end

    // Refresh counter and digit index; both freeze while disabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable) begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_nib[i] = sh_val_q[4*i +: 4];
            nib_zero[i]  = (sh_val_q[4*i +: 4] == 4'h0);
        end
    end

    // A digit is a lead zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lead_zero                 = '0;
        lead_zero[NUM_DIGITS-1]   = nib_zero[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i > 0; i--) begin
            lead_zero[i] = lead_zero[i+1] & nib_zero[i];
        end
    end

    // Output stage computed from the current scan state; a blanked digit hides its dp.
    always_comb begin
        an_n_d = '1;
        if (enable && (cnt_q >= CNT_W'(GUARD))) begin
            an_n_d[idx_q] = 1'b0;
        end
        nibble_d = digit_nib[idx_q];
        blank_d  = blank_lz & lead_zero[idx_q];
        dp_n_d   = blank_d | ~sh_dp_q[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_n_q   <= '1;
            nibble_q <= 4'h0;
            dp_n_q   <= 1'b1;
            blank_q  <= 1'b1;
        end else begin
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_n_q   <= an_n_d;
            nibble_q <= nibble_d;
            dp_n_q   <= dp_n_d;
            blank_q  <= blank_d;
        end
    end

    assign an_n   = an_n_q;
    assign nibble = nibble_q;
    assign dp_n   = dp_n_q;
    assign blank  = blank_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan controller for a common-anode, multi-digit 7-segment display. It latches a packed hex value and decimal-point mask, then cycles through the digits. For each digit it presents the 4-bit nibble to the downstream hex-to-7-segment decoder and drives the active-low anode, decimal-point and blanking outputs. It sits between the datapath that produces the number and the segment decoder feeding the board pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clk cycles each digit is selected (>= GUARD+2).
- GUARD, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value_in  input  4*NUM_DIGITS  packed hex value; nibble i = value_in[4i+3:4i]; digit 0 is the rightmost digit.
- dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- load  input  1  single-cycle strobe; latches value_in and dp_in into the shadow registers.
- enable  input  1  1 = scanning; 0 = display dark and scan frozen.
- blank_lz  input  1  1 = blank leading zeros.
- nibble  output  4  hex digit for the decoder's x input.
- an_n  output  NUM_DIGITS  anode selects, active low, at most one low.
- dp_n  output  1  decimal point, active low.
- blank  output  1  1 = top level forces the segments to 7'b1111111 for the current digit.

## Operation
- Shadow registers sh_val and sh_dp load on any cycle with load=1. They are the only source of displayed data. Input changes without load have no effect.
- Refresh counter cnt runs 0..REFRESH_DIV-1 while enable=1. At the terminal count it wraps to 0 and digit index idx advances by 1, wrapping from NUM_DIGITS-1 to 0. Scan order is 0,1,2,...
- When enable=0, cnt and idx hold their values, and an_n is all ones on the next edge. On re-enable, scanning resumes from the held cnt/idx.
- Lead-zero rule for digit i (i>0): the digit is a lead zero when nibbles NUM_DIGITS-1 down to i of sh_val are all 0. Digit 0 is never a lead zero.
- Output register, updated every edge from the current state:
  - an_n: bit idx = 0 only when enable=1 and cnt>=GUARD; all other bits 1.
  - nibble = sh_val nibble idx.
  - dp_n = ~sh_dp[idx].
  - blank = blank_lz AND (digit idx is a lead zero). A blanked digit also forces dp_n=1.
- A load mid-slot changes nibble, dp_n and blank on the edge after the shadow update. It does not restart cnt or idx.
- Reset mid-operation: all state and outputs go to reset values immediately, asynchronously. Scanning restarts at digit 0, cnt=0.

## Timing
- Reset values: cnt=0, idx=0, sh_val=0, sh_dp=0, an_n=all ones, nibble=0, dp_n=1, blank=1.
- All outputs are registered and lag cnt/idx by one cycle.
- Digit slot = REFRESH_DIV cycles. Anode low for REFRESH_DIV-GUARD cycles, starting one cycle after cnt reaches GUARD.
- Full frame = NUM_DIGITS*REFRESH_DIV cycles.
- load to visible output: 2 edges (shadow register, then output register).
- load coinciding with an idx advance: the new idx shows the new value.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset: hold rst_n=0 with random inputs -> an_n=4'b1111, dp_n=1, blank=1, nibble=0. Assert rst_n=0 asynchronously mid-slot -> outputs return to these values before the next edge.
- Scan: load value_in=16'h1234, enable=1, blank_lz=0 -> nibble sequence 4,3,2,1 repeating. an_n = 1110, 1101, 1011, 0111, each low for 6 cycles after 2 dark cycles. Frame = 32 cycles.
- Lead zeros: load 16'h0050, blank_lz=1 -> blank=1 on digits 3 and 2, blank=0 on digits 1 and 0 (nibble 5, 0). Load 16'h0000 -> only digit 0 unblanked, showing 0. blank_lz=0 -> no blanking.
- Decimal point: load dp_in=4'b0100 with 16'h1234 -> dp_n=0 only while idx=2. Same dp_in with 16'h0034, blank_lz=1 -> dp_n stays 1 on digit 2 (blanked).
- Enable: deassert enable at idx=1, cnt=5 -> an_n=1111 on the next edge and idx/cnt frozen. Re-enable -> resumes at idx=1, cnt=5.
- Mid-slot load: during digit 2 showing 2, pulse load with 16'hABCD -> nibble=B two edges after the load edge. Slot timing is unchanged.
